// File: rtl/ctrl_dmem_unit_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_dmem_unit_pkg
//
// Shared definitions for the single-cycle control decoder and data memory.
//   - Opcode constants for the supported MIPS subset.
//   - Data width of the datapath and memory words.
//   - Packed structs grouping the instruction-class flags and the datapath
//     controls, plus pure helper functions that compute them from an opcode.
// ----------------------------------------------------------------------------
package ctrl_dmem_unit_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;

    // Instruction-class flags: one-hot for a recognised opcode, all zero
    // otherwise.
    typedef struct packed {
        logic rtype;
        logic lw;
        logic sw;
        logic jump;
        logic branch;
    } iclass_t;

    // Datapath controls derived from the class flags.
    typedef struct packed {
        logic reg_dst;
        logic alu_src;
        logic reg_write;
        logic mem2reg;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

    function automatic iclass_t decode_class(input logic [OP_W-1:0] op);
        iclass_t c;
        c = '0;
        case (op)
            OP_RTYPE: c.rtype  = 1'b1;
            OP_LW:    c.lw     = 1'b1;
            OP_SW:    c.sw     = 1'b1;
            OP_J:     c.jump   = 1'b1;
            OP_BEQ:   c.branch = 1'b1;
            default:  c        = '0;
        endcase
        return c;
    endfunction

    // Unrecognised opcodes fall out of these equations with ALUSrc=1 and
    // no register or memory write, which is the intended safe behaviour.
    function automatic ctrl_t derive_ctrl(input iclass_t c);
        ctrl_t k;
        k.reg_dst   = c.rtype;
        k.alu_src   = ~(c.rtype | c.branch);
        k.reg_write = c.rtype | c.lw;
        k.mem2reg   = c.lw;
        k.mem_read  = c.lw;
        k.mem_write = c.sw;
        return k;
    endfunction

endpackage

// File: rtl/ctrl_dmem_unit_dm_array.sv
// ----------------------------------------------------------------------------
// dm_array
//
// DEPTH x DATA_W register array used as the data memory.
//   - Asynchronous clear: every word is forced to zero while reset is high,
//     and writes are ignored for as long as reset stays high.
//   - One combinational read port, one synchronous (rising clk) write port.
//
// Ports:
//   clk      in   1          write clock
//   reset    in   1          asynchronous, active-high clear
//   we_i     in   1          write enable
//   idx_i    in   AW         word index for both read and write
//   wdata_i  in   DATA_W     write data
//   rdata_o  out  DATA_W     contents of word idx_i
// ----------------------------------------------------------------------------
module dm_array
    import ctrl_dmem_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [AW-1:0]     idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // DEPTH is a power of two, so every idx_i value addresses a real word.
    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/ctrl_dmem_unit.sv
// ----------------------------------------------------------------------------
// ctrl_dmem_unit
//
// Single-cycle control decoder plus word-addressed data memory. The opcode
// is decoded combinationally into class flags and datapath controls; the
// same MemRead/MemWrite controls drive an internal data memory indexed by
// the ALU result, which supplies the load value for write-back.
//
// Ports:
//   clk       in   1    system clock, memory writes on rising edge
//   reset     in   1    asynchronous, active-high; clears the memory only
//   opCode    in   6    instruction bits [31:26]
//   addr      in   32   byte address (ALU result); word index addr[AW+1:2]
//   wdata     in   32   store data
//   rtype, lw, sw, jump, branch   out 1 each   instruction-class flags
//   RegDst    out  1    1 = destination rd, 0 = rt
//   ALUSrc    out  1    1 = ALU B operand is the immediate
//   RegWrite  out  1    register-file write enable
//   Mem2Reg   out  1    1 = write-back selects memOut
//   MemRead   out  1    memory read enable
//   MemWrite  out  1    memory write enable
//   memOut    out  32   load data, zero when MemRead is low
// ----------------------------------------------------------------------------
module ctrl_dmem_unit
    import ctrl_dmem_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OP_W-1:0]   opCode,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              rtype,
    output logic              lw,
    output logic              sw,
    output logic              jump,
    output logic              branch,
    output logic              RegDst,
    output logic              ALUSrc,
    output logic              RegWrite,
    output logic              Mem2Reg,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [DATA_W-1:0] memOut
);

    localparam int unsigned AW = $clog2(DEPTH);

    iclass_t           cls;
    ctrl_t             ctl;
    logic [AW-1:0]     mem_idx;
    logic [DATA_W-1:0] mem_rdata;

    // Decode is a pure function of opCode; reset does not touch it.
    always_comb begin
        cls = decode_class(opCode);
        ctl = derive_ctrl(cls);
    end

    assign rtype    = cls.rtype;
    assign lw       = cls.lw;
    assign sw       = cls.sw;
    assign jump     = cls.jump;
    assign branch   = cls.branch;
    assign RegDst   = ctl.reg_dst;
    assign ALUSrc   = ctl.alu_src;
    assign RegWrite = ctl.reg_write;
    assign Mem2Reg  = ctl.mem2reg;
    assign MemRead  = ctl.mem_read;
    assign MemWrite = ctl.mem_write;

    // Byte offset and bits above the array size are dropped: no alignment
    // trap, and addresses wrap modulo DEPTH words.
    assign mem_idx = addr[AW+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

    dm_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dm_array (
        .clk     (clk),
        .reset   (reset),
        .we_i    (ctl.mem_write),
        .idx_i   (mem_idx),
        .wdata_i (wdata),
        .rdata_o (mem_rdata)
    );

    assign memOut = ctl.mem_read ? mem_rdata : '0;

endmodule

// File: tb/tb_ctrl_dmem_unit.sv
// ----------------------------------------------------------------------------
// tb_ctrl_dmem_unit
//
// Directed-vector bench for ctrl_dmem_unit (DEPTH = 64). Each vector drives
// opCode/addr/wdata, pushes the hand-computed response onto a scoreboard
// queue and raises a sample strobe; an independent monitor pops the queue
// and compares the DUT outputs.
// Control vector bit order:
//   {rtype, lw, sw, jump, branch, RegDst, ALUSrc, RegWrite, Mem2Reg,
//    MemRead, MemWrite}
// ----------------------------------------------------------------------------
module tb_ctrl_dmem_unit;

    localparam logic [10:0] C_R   = 11'b10000_101000;
    localparam logic [10:0] C_LW  = 11'b01000_011110;
    localparam logic [10:0] C_SW  = 11'b00100_010001;
    localparam logic [10:0] C_J   = 11'b00010_010000;
    localparam logic [10:0] C_BEQ = 11'b00001_000000;
    localparam logic [10:0] C_OTH = 11'b00000_010000;

    logic        clk;
    logic        clk_en;
    logic        reset;
    logic [5:0]  opCode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rtype, lw, sw, jump, branch;
    logic        RegDst, ALUSrc, RegWrite, Mem2Reg, MemRead, MemWrite;
    logic [31:0] memOut;

    typedef struct {
        string       name;
        logic [10:0] ctrl;
        logic [31:0] mem;
    } exp_t;

    exp_t sb[$];
    logic sample_req;
    int   n_vec;
    int   n_bad;

    ctrl_dmem_unit #(
        .DEPTH (64)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .opCode   (opCode),
        .addr     (addr),
        .wdata    (wdata),
        .rtype    (rtype),
        .lw       (lw),
        .sw       (sw),
        .jump     (jump),
        .branch   (branch),
        .RegDst   (RegDst),
        .ALUSrc   (ALUSrc),
        .RegWrite (RegWrite),
        .Mem2Reg  (Mem2Reg),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .memOut   (memOut)
    );

    // Gated clock so the bench can hold it idle for the no-edge store case.
    initial clk = 1'b0;
    always begin
        #10;
        if (clk_en) clk = ~clk;
    end

    // Monitor: pops one expectation per sample strobe.
    initial begin
        exp_t        e;
        logic [10:0] act;
        forever begin
            @(sample_req);
            act = {rtype, lw, sw, jump, branch,
                   RegDst, ALUSrc, RegWrite, Mem2Reg, MemRead, MemWrite};
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_underflow: strobe with empty scoreboard");
            end else begin
                e = sb.pop_front();
                if (act !== e.ctrl || memOut !== e.mem) begin
                    n_bad++;
                    $display("FAIL %s: ctrl=%b memOut=%h, expected ctrl=%b memOut=%h",
                             e.name, act, memOut, e.ctrl, e.mem);
                end
            end
        end
    end

    // sync=1: wait for the next falling edge first, so any store driven by
    // the previous vector is committed by the rising edge in between.
    task automatic vec(input string name, input bit sync, input logic [5:0] op,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [10:0] ec, input logic [31:0] em);
        exp_t e;
        if (sync) begin
            @(negedge clk);
            #1;
        end
        opCode = op;
        addr   = a;
        wdata  = wd;
        #1;
        e.name = name;
        e.ctrl = ec;
        e.mem  = em;
        sb.push_back(e);
        sample_req = ~sample_req;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec      = 0;
        n_bad      = 0;
        sample_req = 1'b0;
        clk_en     = 1'b1;
        reset      = 1'b0;
        opCode     = 6'h23;
        addr       = 32'h10;
        wdata      = '0;
        #1;
        reset = 1'b1;
        vec("rst_lw_during",  0, 6'h23, 32'h10, '0, C_LW, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
        vec("rst_lw_after",   0, 6'h23, 32'h10, '0, C_LW, 32'h0);

        // Opcode sweep
        vec("dec_rtype",      1, 6'h00, 32'h10, '0, C_R,   32'h0);
        vec("dec_lw",         1, 6'h23, 32'h10, '0, C_LW,  32'h0);
        vec("dec_sw",         0, 6'h2B, 32'h10, '0, C_SW,  32'h0);
        vec("dec_j",          1, 6'h02, 32'h10, '0, C_J,   32'h0);
        vec("dec_beq",        0, 6'h04, 32'h10, '0, C_BEQ, 32'h0);
        vec("dec_addi",       1, 6'h08, 32'h10, '0, C_OTH, 32'h0);
        vec("dec_3f",         0, 6'h3F, 32'h10, '0, C_OTH, 32'h0);

        // Store, then load with and without byte offset
        vec("sw_14",          1, 6'h2B, 32'h14, 32'hDEADBEEF, C_SW, 32'h0);
        vec("lw_14",          1, 6'h23, 32'h14, '0, C_LW, 32'hDEADBEEF);
        vec("lw_17",          0, 6'h23, 32'h17, '0, C_LW, 32'hDEADBEEF);

        // Address wrap: 0x108 -> word 2
        vec("sw_108",         1, 6'h2B, 32'h108, 32'h1234, C_SW, 32'h0);
        vec("lw_8_wrap",      1, 6'h23, 32'h8,   '0, C_LW, 32'h1234);
        vec("lw_108",         0, 6'h23, 32'h108, '0, C_LW, 32'h1234);

        // Highest word and untouched word 0
        vec("sw_fc",          1, 6'h2B, 32'hFC, 32'hCAFEF00D, C_SW, 32'h0);
        vec("lw_fc",          1, 6'h23, 32'hFC, '0, C_LW, 32'hCAFEF00D);
        vec("lw_0",           0, 6'h23, 32'h0,  '0, C_LW, 32'h0);

        // MemRead low hides stored data
        vec("rtype_14_gated", 1, 6'h00, 32'h14, '0, C_R, 32'h0);

        // Store with the clock held idle must not write
        clk_en = 1'b0;
        vec("sw_14_noclk",    0, 6'h2B, 32'h14, 32'h5555, C_SW, 32'h0);
        #30;
        vec("lw_14_noclk",    0, 6'h23, 32'h14, '0, C_LW, 32'hDEADBEEF);
        clk_en = 1'b1;

        vec("sw_20",          1, 6'h2B, 32'h20, 32'hA5A5A5A5, C_SW, 32'h0);
        vec("lw_20",          1, 6'h23, 32'h20, '0, C_LW, 32'hA5A5A5A5);

        // Asynchronous reset between edges clears immediately
        reset = 1'b1;
        vec("lw_20_async_rst", 0, 6'h23, 32'h20, '0, C_LW, 32'h0);
        vec("lw_14_async_rst", 0, 6'h23, 32'h14, '0, C_LW, 32'h0);
        vec("sw_24_in_rst",    0, 6'h2B, 32'h24, 32'h77, C_SW, 32'h0);
        vec("lw_24_in_rst",    1, 6'h23, 32'h24, '0, C_LW, 32'h0);
        reset = 1'b0;
        vec("lw_24_post_rst",  0, 6'h23, 32'h24, '0, C_LW, 32'h0);

        // First edge after deassertion accepts a write
        vec("sw_24",          1, 6'h2B, 32'h24, 32'h99, C_SW, 32'h0);
        vec("lw_24",          1, 6'h23, 32'h24, '0, C_LW, 32'h99);
        vec("lw_fc_cleared",  0, 6'h23, 32'hFC, '0, C_LW, 32'h0);

        #5;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
